// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks, per architectural register, how many stages
// ago its newest in-flight writer left ID, and from that decides whether each
// ID source operand comes from the register file, a forwarding stage, or must
// stall.
module fwd_scoreboard #(
  parameter  int NREG      = 8,
  parameter  int NSRC      = 3,
  parameter  int DEPTH     = 3,
  parameter  int FIRST_FWD = 2,
  localparam int AW        = $clog2(NREG),
  localparam int SW        = $clog2(DEPTH - FIRST_FWD + 2)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               adv,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic               issue_late,
  input  logic               flush,
  input  logic [NSRC-1:0]    src_en,
  input  logic [NSRC*AW-1:0] src_reg,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic               stall,
  output logic [NREG-1:0]    pending
);

  localparam int AGW = $clog2(DEPTH + 1);
  localparam logic [AGW-1:0] AGE_ONE = AGW'(1);
  localparam logic [AGW-1:0] AGE_MAX = AGW'(DEPTH);

  // Age 0 = value is architectural; 1..DEPTH = stage holding the newest writer.
  logic [AGW-1:0] age_q [NREG];
  logic [AGW-1:0] age_d [NREG];
  logic [NREG-1:0] late_q;
  logic [NREG-1:0] late_d;
  logic [NSRC-1:0] port_stall;

  // Per-register busy flags straight from the age counters.
  for (genvar r = 0; r < NREG; r++) begin : g_pend
    assign pending[r] = (age_q[r] != '0);
  end

  // Per-port lookup against the current (pre-edge) state, so an issue to the
  // same register in this cycle is never seen by this cycle's reads.
  for (genvar i = 0; i < NSRC; i++) begin : g_port
    logic [AW-1:0]  reg_idx;
    logic [AGW-1:0] age;
    logic           late;
    logic           busy;
    logic           ready;
    logic [SW-1:0]  sel;

    assign reg_idx = src_reg[i*AW +: AW];
    assign age     = age_q[reg_idx];
    assign late    = late_q[reg_idx];
    assign busy    = (age != '0);
    // A late (load) result surfaces one stage further down the pipe.
    assign ready   = (int'(age) - int'(late)) >= FIRST_FWD;
    assign sel     = SW'(int'(age) - FIRST_FWD + 1);

    assign port_stall[i]        = src_en[i] & busy & ~ready;
    assign fwd_sel[i*SW +: SW]  = (src_en[i] & busy & ready) ? sel : '0;
  end

  assign stall = |port_stall;

  // Next-state: age every in-flight entry, retire at DEPTH, squash age 1 on
  // flush, then let an accepted issue overwrite its destination.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    age_d  = age_q;
    late_d = late_q;
    if (adv) begin
      for (int r = 0; r < NREG; r++) begin
        if (age_q[r] == AGE_MAX || (flush && age_q[r] == AGE_ONE)) begin
          age_d[r]  = '0;
          late_d[r] = 1'b0;
        end else if (age_q[r] != '0) begin
          age_d[r] = age_q[r] + AGE_ONE;
        end
      end
      // Newest writer wins over both ageing and flush of the same register.
      if (issue_valid && !stall) begin
        age_d[issue_rd]  = AGE_ONE;
        late_d[issue_rd] = issue_late;
      end
    end
  end

  // State registers with asynchronous clear of every in-flight entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this is a handful of flops, not a RAM, and stale ages after reset
      // would raise false stalls, so the whole array is cleared.
      age_q  <= '{default: '0};
      late_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      age_q  <= age_d;
      late_q <= late_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard at default parameters: a table of
// hand-derived cycle vectors plus hand-written reset sequences.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       adv;
  logic       issue_valid;
  logic [2:0] issue_rd;
  logic       issue_late;
  logic       flush;
  logic [2:0] src_en;
  logic [8:0] src_reg;
  logic [5:0] fwd_sel;
  logic       stall;
  logic [7:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       adv;
    logic       iv;
    logic [2:0] rd;
    logic       late;
    logic       flush;
    logic [2:0] en;
    logic [8:0] regs;
    logic [5:0] sel;
    logic       stall;
    logic [7:0] pend;
  } vec_t;

  typedef struct {
    string      tag;
    logic [5:0] sel;
    logic       stall;
    logic [7:0] pend;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  fwd_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adv        (adv),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_late (issue_late),
    .flush      (flush),
    .src_en     (src_en),
    .src_reg    (src_reg),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic iv, input int rd, input logic late,
                              input logic fl, input logic [2:0] en,
                              input int r0, input int r1, input int r2,
                              input int s0, input int s1, input int s2,
                              input logic st, input logic [7:0] pd);
    vec_t v;
    v.adv   = a;
    v.iv    = iv;
    v.rd    = 3'(rd);
    v.late  = late;
    v.flush = fl;
    v.en    = en;
    v.regs  = {3'(r2), 3'(r1), 3'(r0)};
    v.sel   = {2'(s2), 2'(s1), 2'(s0)};
    v.stall = st;
    v.pend  = pd;
    return v;
  endfunction

  // One pipeline cycle: drive after the rising edge, push the expectation,
  // compare at the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    adv         = v.adv;
    issue_valid = v.iv;
    issue_rd    = v.rd;
    issue_late  = v.late;
    flush       = v.flush;
    src_en      = v.en;
    src_reg     = v.regs;
    exp_q.push_back('{tag, v.sel, v.stall, v.pend});
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, " fwd_sel"}, 32'(fwd_sel), 32'(e.sel));
    check({e.tag, " stall"},   32'(stall),   32'(e.stall));
    check({e.tag, " pending"}, 32'(pending), 32'(e.pend));
  endtask

  task automatic idle_inputs();
    adv = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_late = 1'b0;
    flush = 1'b0; src_en = '0; src_reg = '0;
  endtask

  initial begin
    // Reset with live-looking inputs: nothing may be captured.
    reset_n = 1'b0;
    adv = 1'b1; issue_valid = 1'b1; issue_rd = 3'd1; issue_late = 1'b0; flush = 1'b0;
    src_en = 3'b111; src_reg = {3'd3, 3'd2, 3'd1};
    #7;
    check("rst pending", 32'(pending), 32'h0);
    check("rst stall",   32'(stall),   32'h0);
    check("rst fwd_sel", 32'(fwd_sel), 32'h0);
    idle_inputs();
    #5 reset_n = 1'b1;

    //            adv iv rd lt fl  en     r0 r1 r2  s0 s1 s2 st  pend
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b111, 0, 1, 2, 0, 0, 0, 0, 8'h00)); // empty
    // Normal writer to r3
    tbl.push_back(mk(1, 1, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 1, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 1, 0, 0, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 2, 0, 0, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 0, 8'h00));
    // Late writer to r5, read on port 1
    tbl.push_back(mk(1, 1, 5, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b010, 0, 5, 0, 0, 0, 0, 1, 8'h20));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b010, 0, 5, 0, 0, 0, 0, 1, 8'h20));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b010, 0, 5, 0, 0, 2, 0, 0, 8'h20));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b010, 0, 5, 0, 0, 0, 0, 0, 8'h00));
    // Back-to-back writers to r2, read on port 2: newest one wins
    tbl.push_back(mk(1, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 2, 0, 0, 0, 1, 8'h04));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 2, 0, 0, 1, 0, 8'h04));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 2, 0, 0, 2, 0, 8'h04));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0, 2, 0, 0, 0, 0, 8'h00));
    // Freeze with r1 in flight; flush and issue ignored while frozen
    tbl.push_back(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 1, 8'h02));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b001, 1, 0, 0, 0, 0, 0, 1, 8'h02));
    tbl.push_back(mk(0, 1, 6, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 1, 8'h02));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 1, 8'h02));
    tbl.push_back(mk(0, 1, 6, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h02));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 1, 0, 0, 0, 8'h02));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2, 0, 0, 0, 8'h02));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    // Flush squashes r4 at age 1
    tbl.push_back(mk(1, 1, 4, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 4, 0, 0, 0, 0, 0, 0, 8'h00));
    // Stall suppresses issue; read-before-write on same register
    tbl.push_back(mk(1, 1, 7, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 6, 0, 0, 3'b001, 7, 0, 0, 0, 0, 0, 1, 8'h80));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b010, 0, 6, 0, 0, 0, 0, 0, 8'h80));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3'b101, 0, 0, 7, 0, 0, 2, 0, 8'h80));
    tbl.push_back(mk(1, 1, 5, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 1, 8'h01));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h01));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h01));
    // Issue beats flush; flush leaves age 2 alone
    tbl.push_back(mk(1, 1, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 1, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3'b001, 3, 0, 0, 1, 0, 0, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 2, 0, 0, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Three writers in flight, then reset between clock edges.
    run_vec(mk(1, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h00), "mr_i1");
    run_vec(mk(1, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h02), "mr_i2");
    run_vec(mk(1, 1, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'h06), "mr_i3");
    run_vec(mk(0, 0, 0, 0, 0, 3'b111, 1, 2, 3, 2, 1, 0, 1, 8'h0E), "mr_rd");
    #2 reset_n = 1'b0;
    #1;
    check("mr async pending", 32'(pending), 32'h0);
    check("mr async stall",   32'(stall),   32'h0);
    check("mr async fwd_sel", 32'(fwd_sel), 32'h0);
    #4;
    check("mr held pending", 32'(pending), 32'h0);
    idle_inputs();
    #1 reset_n = 1'b1;
    run_vec(mk(1, 1, 3, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 0, 8'h00), "pr_i3");
    run_vec(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 1, 8'h08), "pr_r1");
    run_vec(mk(1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 1, 0, 0, 0, 8'h08), "pr_r2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NREG, default 8, number of architectural registers; AW = clog2(NREG).
REQ-002 Parameter NSRC, default 3, number of source-operand lookup ports.
REQ-003 Parameter DEPTH, default 3, number of stages after ID that hold a result (EX=1 .. WB=DEPTH).
REQ-004 Parameter FIRST_FWD, default 2, first stage whose result is forwardable; SW = clog2(DEPTH-FIRST_FWD+2).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 adv  in  1  pipeline advances this cycle; 0 = global freeze.
REQ-008 issue_valid  in  1  ID instruction writes a register.
REQ-009 issue_rd  in  AW  destination register of the ID instruction.
REQ-010 issue_late  in  1  result becomes available one stage later than normal (load).
REQ-011 flush  in  1  squash the instruction currently in EX (age 1).
REQ-012 src_en  in  NSRC  per-port: operand is read by the ID instruction.
REQ-013 src_reg  in  NSRC*AW  per-port register index, port i at bits [i*AW +: AW].
REQ-014 fwd_sel  out  NSRC*SW  per-port source: 0 = register file, k = stage FIRST_FWD+k-1.
REQ-015 stall  out  1  ID instruction must hold; a bubble enters EX.
REQ-016 pending  out  NREG  per-register: a write is in flight (age != 0).

Function
REQ-017 Each register shall hold an age counter 0..DEPTH and a late bit; age 0 = value valid in register file.
REQ-018 Effective readiness age shall be age - late; ready when age = 0 or (age - late) >= FIRST_FWD.
REQ-019 For enabled port i with age(r) = 0: fwd_sel_i = 0; with age >= FIRST_FWD and ready: fwd_sel_i = age - FIRST_FWD + 1.
REQ-020 stall shall be 1 when any enabled port references a register that is pending and not ready; disabled ports never cause stall; fwd_sel of a disabled or stalling port shall be 0.
REQ-021 fwd_sel, stall and pending shall be combinational from current state and inputs (zero latency).
REQ-022 adv = 0: all ages and late bits hold; issue_valid and flush ignored.
REQ-023 adv = 1: every nonzero age increments by 1; an age equal to DEPTH becomes 0 and clears its late bit.
REQ-024 adv = 1, issue_valid = 1, stall = 0: age[issue_rd] <= 1 and late[issue_rd] <= issue_late, overriding the increment of REQ-023 (newest writer wins).
REQ-025 adv = 1 with stall = 1: issue is suppressed; ages still increment (bubble behaviour).
REQ-026 flush = 1 with adv = 1: the register at age 1 shall go to 0 instead of 2; same-cycle issue still applies (issue beats flush on the same register).
REQ-027 Two registers shall never share an age of 1 or higher from distinct issues in the same cycle; only one issue per cycle is accepted.
REQ-028 An issue_rd equal to a src_reg of the same cycle shall be evaluated against the old state (read-before-write).

Reset
REQ-029 reset_n low shall immediately clear all ages and late bits; pending = 0, stall = 0, fwd_sel = 0 while in reset.
REQ-030 Reset asserted mid-operation shall discard all in-flight entries; first cycle after release behaves as empty scoreboard.

Verification
REQ-031 Issue r3 (adv=1), next cycle read r3 on port 0 -> stall=1; next cycle -> stall=0, fwd_sel0=1; next -> fwd_sel0=2; next -> fwd_sel0=0, pending[3]=0.
REQ-032 Issue r5 with issue_late=1, read r5 each cycle -> stall=1 at ages 1 and 2, fwd_sel=2 at age 3, then 0.
REQ-033 Issue r2, then r2 again one cycle later -> age[r2]=1 after second issue; read sees stall, then fwd_sel=1 (newest), no stale age-2 selection.
REQ-034 Issue r1, hold adv=0 for 4 cycles while reading r1 -> stall=1 and pending[1]=1 constant; ages resume on adv=1.
REQ-035 Issue r4, assert flush next cycle with adv=1 -> pending[4]=0, read of r4 gives fwd_sel=0, stall=0.
REQ-036 Three writes in flight, drop reset_n asynchronously between edges -> pending=0 immediately; after release, issue of stalling rd is accepted normally.
